// File: rtl/memory_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: requester IDs, the SRAM
// request bundle and the arbiter FSM encoding, plus small helpers.
package memory_arbiter_params;

  localparam int SRAM_ADDR_WIDTH = 32;
  localparam int SRAM_DATA_WIDTH = 32;

  typedef enum logic {
    REQUESTER_INST = 1'b0,
    REQUESTER_DATA = 1'b1
  } RequesterId;

  // Request fields at the default SRAM widths.
  typedef struct packed {
    logic                             wr;
    logic [1:0]                       size;
    logic [SRAM_ADDR_WIDTH-1:0]       addr;
    logic [SRAM_DATA_WIDTH/8-1:0]     wstrb;
    logic [SRAM_DATA_WIDTH-1:0]       wdata;
  } SramRequest;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } ArbiterState;

  // The requester that is not `id`.
  function automatic RequesterId other_requester(input RequesterId id);
    return (id == REQUESTER_INST) ? REQUESTER_DATA : REQUESTER_INST;
  endfunction

  // Lock state that holds a grant for `id` while its address phase waits.
  function automatic ArbiterState lock_state_for(input RequesterId id);
    return (id == REQUESTER_DATA) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage

// File: rtl/memory_request_arbiter_request_order_fifo.sv
// Order FIFO holding the requester ID of every accepted, unanswered
// transaction. Pointers wrap modulo DEPTH; count runs 0..DEPTH.
module request_order_fifo
  import memory_arbiter_params::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  RequesterId                   push_id,
  input  logic                         pop,
  output RequesterId                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  RequesterId        mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign empty = (count_r == '0);
  assign full  = (count_r == CNT_W'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= REQUESTER_INST;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_id;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/memory_request_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store.
// One requester owns each address phase until it is accepted; owner IDs of
// accepted transactions are queued so in-order responses return to them.
// Build option: MEM_ARB_ROUND_ROBIN_EN alternates the winner of conflicts;
// otherwise data always beats inst.
module memory_request_arbiter
  import memory_arbiter_params::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inst_req,
  input  logic                    inst_wr,
  input  logic [1:0]              inst_size,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic [DATA_WIDTH/8-1:0] inst_wstrb,
  input  logic [DATA_WIDTH-1:0]   inst_wdata,
  output logic                    inst_addr_ok,
  output logic                    inst_data_ok,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  input  logic                    data_req,
  input  logic                    data_wr,
  input  logic [1:0]              data_size,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_addr_ok,
  output logic                    data_data_ok,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [1:0]              mem_size,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_addr_ok,
  input  logic                    mem_data_ok,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    protocol_error
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ArbiterState       state_r;
  ArbiterState       state_nxt_s;
  RequesterId        pick_s;
  RequesterId        owner_s;
  logic              owner_req_s;
  logic              grant_allow_s;
  logic              accept_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  RequesterId        head_s;
  logic [CNT_W-1:0]  count_s;
  logic              empty_s;
  logic              full_s;
  logic              protocol_error_r;

  // New grants only while there is room for another outstanding transaction.
  assign grant_allow_s = (count_s < CNT_W'(MAX_OUTSTANDING));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  RequesterId last_winner_r;
  logic       conflict_lock_r;
  logic       conflict_s;

  assign conflict_s = inst_req & data_req;

  // Winner selection: conflicts go to whoever lost the last accepted conflict.
  always_comb begin
    if (conflict_s) begin
      pick_s = other_requester(last_winner_r);
    end else if (data_req) begin
      pick_s = REQUESTER_DATA;
    end else begin
      pick_s = REQUESTER_INST;
    end
  end

  // Remember the winner of a conflict once its address phase is accepted,
  // including conflicts whose grant had to wait in a lock state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_winner_r   <= REQUESTER_INST;
      conflict_lock_r <= 1'b0;
    end else if ((state_r == IDLE) && grant_allow_s && conflict_s) begin
      if (mem_addr_ok) begin
        last_winner_r <= pick_s;
      end else begin
        conflict_lock_r <= 1'b1;
      end
    end else if ((state_r != IDLE) && mem_addr_ok) begin
      if (conflict_lock_r) begin
        last_winner_r <= owner_s;
      end else begin
        last_winner_r <= last_winner_r;
      end
      conflict_lock_r <= 1'b0;
    end else begin
      last_winner_r   <= last_winner_r;
      conflict_lock_r <= conflict_lock_r;
    end
  end
`else
  // Winner selection: data always beats inst.
  always_comb begin
    if (data_req) begin
      pick_s = REQUESTER_DATA;
    end else begin
      pick_s = REQUESTER_INST;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: lock onto an owner whose address phase is stalled.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (owner_req_s && !mem_addr_ok) begin
          state_nxt_s = lock_state_for(owner_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK_INST, LOCK_DATA: begin
        if (mem_addr_ok) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: current owner and whether it is requesting.
  always_comb begin
    owner_s     = REQUESTER_INST;
    owner_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        owner_s = pick_s;
        if (grant_allow_s) begin
          owner_req_s = inst_req | data_req;
        end else begin
          owner_req_s = 1'b0;
        end
      end
      LOCK_INST: begin
        owner_s     = REQUESTER_INST;
        owner_req_s = inst_req;
      end
      LOCK_DATA: begin
        owner_s     = REQUESTER_DATA;
        owner_req_s = data_req;
      end
      default: begin
        owner_s     = REQUESTER_INST;
        owner_req_s = 1'b0;
      end
    endcase
  end

  // Downstream request fields follow the owner combinationally.
  assign mem_req   = reset & owner_req_s;
  assign mem_wr    = (owner_s == REQUESTER_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (owner_s == REQUESTER_DATA) ? data_size  : inst_size;
  assign mem_addr  = (owner_s == REQUESTER_DATA) ? data_addr  : inst_addr;
  assign mem_wstrb = (owner_s == REQUESTER_DATA) ? data_wstrb : inst_wstrb;
  assign mem_wdata = (owner_s == REQUESTER_DATA) ? data_wdata : inst_wdata;

  assign accept_s     = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept_s & (owner_s == REQUESTER_INST);
  assign data_addr_ok = accept_s & (owner_s == REQUESTER_DATA);

  // A response with nothing outstanding is unexpected and pops nothing.
  assign fifo_pop_s  = mem_data_ok & ~empty_s;
  assign fifo_push_s = accept_s & (~full_s | fifo_pop_s);

  request_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push_s),
    .push_id (owner_s),
    .pop     (fifo_pop_s),
    .head    (head_s),
    .count   (count_s),
    .empty   (empty_s),
    .full    (full_s)
  );

  // Responses return to the oldest outstanding owner; read data is shared.
  assign inst_data_ok = reset & fifo_pop_s & (head_s == REQUESTER_INST);
  assign data_data_ok = reset & fifo_pop_s & (head_s == REQUESTER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      protocol_error_r <= 1'b0;
    end else if (mem_data_ok && empty_s) begin
      protocol_error_r <= 1'b1;
    end else begin
      protocol_error_r <= protocol_error_r;
    end
  end

  assign protocol_error = protocol_error_r;

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Scoreboard bench for memory_request_arbiter: a transaction-level model
// predicts grants and response routing; a negedge monitor compares.
module tb_memory_request_arbiter;
  import memory_arbiter_params::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXO = 2;

  logic          clock, reset;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [SW-1:0] inst_wstrb, data_wstrb;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] mem_rdata;
  logic          protocol_error;

  memory_request_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .protocol_error(protocol_error)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    bit [3:0]  ctl;        // {mem_req, inst_addr_ok, data_addr_ok, protocol_error}
    bit [70:0] fields;     // {wr, size, addr, wstrb, wdata} of the owner
    bit        data_exp;   // a response is due this cycle
  } addr_item_t;

  typedef struct {
    bit        owner_data;
    bit [31:0] rdata;
  } resp_item_t;

  addr_item_t addr_q[$];
  resp_item_t resp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: outstanding owners in acceptance order,
  // the owner currently holding a stalled grant (-1: none), sticky error.
  bit m_q[$];
  int m_lock;
  bit m_perr;
  bit m_last;      // owner of the last accepted conflict (0 = inst)
  bit m_conf;      // the held grant came from a conflict
  bit m_inst_acc, m_data_acc;
  bit inst_pend, data_pend;

  task automatic model_eval();
    addr_item_t e;
    resp_item_t r;
    bit owner, mreq, acc, conflict;
    e.ctl = 4'd0; e.fields = '0; e.data_exp = 1'b0;
    m_inst_acc = 1'b0; m_data_acc = 1'b0;
    if (!reset) begin
      m_q.delete(); m_lock = -1; m_perr = 1'b0; m_last = 1'b0; m_conf = 1'b0;
      addr_q.push_back(e);
      return;
    end
    conflict = 1'b0;
    owner = 1'b0;
    mreq = 1'b0;
    if (m_lock >= 0) begin
      owner = (m_lock == 1);
      mreq  = owner ? data_req : inst_req;
    end else if (m_q.size() < MAXO && (inst_req || data_req)) begin
      mreq = 1'b1;
      conflict = inst_req && data_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      owner = conflict ? ~m_last : data_req;
`else
      owner = data_req;
`endif
    end
    acc = mreq && mem_addr_ok;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (m_lock < 0 && conflict) begin
      if (mem_addr_ok) m_last = owner;
      else m_conf = 1'b1;
    end else if (m_lock >= 0 && mem_addr_ok) begin
      if (m_conf) m_last = owner;
      m_conf = 1'b0;
    end
`endif
    if (m_lock < 0 && mreq && !mem_addr_ok) m_lock = owner;
    else if (m_lock >= 0 && mem_addr_ok) m_lock = -1;
    e.ctl = {mreq, acc && !owner, acc && owner, m_perr};
    e.fields = owner ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                     : {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
    if (mem_data_ok) begin
      if (m_q.size() > 0) begin
        r.owner_data = m_q.pop_front();
        r.rdata = mem_rdata;
        resp_q.push_back(r);
        e.data_exp = 1'b1;
      end else begin
        m_perr = 1'b1;
      end
    end
    if (acc) m_q.push_back(owner);
    m_inst_acc = acc && !owner;
    m_data_acc = acc && owner;
    addr_q.push_back(e);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  // Monitor: compare one cycle of expectations, and any response the DUT shows.
  always @(negedge clock) begin
    addr_item_t e;
    resp_item_t r;
    if (addr_q.size() > 0) begin
      e = addr_q.pop_front();
      vectors++;
      if ({mem_req, inst_addr_ok, data_addr_ok, protocol_error} !== e.ctl) begin
        miscompares++;
        $display("FAIL ctl t=%0t req/iok/dok/perr got %b want %b", $time,
                 {mem_req, inst_addr_ok, data_addr_ok, protocol_error}, e.ctl);
      end
      if (e.ctl[3]) begin
        vectors++;
        if ({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} !== e.fields) begin
          miscompares++;
          $display("FAIL fields t=%0t got %h want %h", $time,
                   {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, e.fields);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        vectors++;
        if (!e.data_exp || resp_q.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected t=%0t got iok=%b dok=%b want none", $time,
                   inst_data_ok, data_data_ok);
        end else begin
          r = resp_q.pop_front();
          if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !==
              {~r.owner_data, r.owner_data, r.rdata, r.rdata}) begin
            miscompares++;
            $display("FAIL resp t=%0t got i=%b d=%b rd=%h/%h want i=%b d=%b rd=%h", $time,
                     inst_data_ok, data_data_ok, inst_rdata, data_rdata,
                     ~r.owner_data, r.owner_data, r.rdata);
          end
        end
      end else if (e.data_exp) begin
        vectors++;
        miscompares++;
        $display("FAIL resp_missing t=%0t got no data_ok want one", $time);
        if (resp_q.size() > 0) void'(resp_q.pop_front());
      end
    end
  end

  initial begin
    m_lock = -1; m_perr = 1'b0; m_last = 1'b0; m_conf = 1'b0;
    inst_pend = 1'b0; data_pend = 1'b0;
    reset = 1'b0;
    quiet();
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    mem_rdata = '0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Simultaneous requests accepted at once; responses follow acceptance order.
    inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000; data_wr = 1'b1;
    data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; tick();
    data_req = 1'b0; tick();
    quiet(); mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick();
    mem_rdata = 32'h0BAD_F00D; tick();
    quiet(); tick();

    // Stalled inst grant keeps its address while data arrives later.
    data_wr = 1'b0; inst_addr = 32'hBFC0_0000; data_addr = 32'h8000_0040;
    inst_req = 1'b1; tick();
    data_req = 1'b1; tick();
    tick();
    mem_addr_ok = 1'b1; tick();
    inst_req = 1'b0; tick();
    quiet(); mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111; tick();
    mem_rdata = 32'h2222_2222; tick();
    quiet(); tick();

    // Outstanding limit: third request waits, even across a pop cycle.
    inst_req = 1'b1; mem_addr_ok = 1'b1; tick();
    inst_req = 1'b0; data_req = 1'b1; tick();
    data_req = 1'b0; inst_req = 1'b1; tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h3333_3333; tick();
    mem_data_ok = 1'b0; tick();
    quiet(); mem_data_ok = 1'b1; mem_rdata = 32'h4444_4444; tick();
    mem_rdata = 32'h5555_5555; tick();
    quiet(); tick();

    // Push and pop in one cycle with one outstanding.
    inst_req = 1'b1; mem_addr_ok = 1'b1; tick();
    inst_req = 1'b0; data_req = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h6666_6666; tick();
    quiet(); mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777; tick();
    quiet(); tick();

    // Unexpected response sets the sticky error until reset.
    mem_data_ok = 1'b1; tick();
    quiet(); tick(); tick();
    reset = 1'b0; tick();
    reset = 1'b1; tick();

    // Back-to-back conflicts, then reset drops the outstanding transaction.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      mem_data_ok = 1'b1; mem_rdata = DW'(32'hA000_0000 + k); tick();
    end
    quiet(); reset = 1'b0; tick();
    reset = 1'b1; mem_data_ok = 1'b1; tick();
    quiet(); reset = 1'b0; tick();
    reset = 1'b1; tick();

    // Randomized traffic honouring the hold-until-accepted rule.
    for (int i = 0; i < 1500; i++) begin
      if (!inst_pend && ($urandom_range(2) == 0)) begin
        inst_pend = 1'b1; inst_wr = 1'b0; inst_size = 2'($urandom_range(2));
        inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      end
      if (!data_pend && ($urandom_range(2) == 0)) begin
        data_pend = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom_range(2));
        data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      inst_req = inst_pend;
      data_req = data_pend;
      mem_addr_ok = 1'($urandom);
      mem_data_ok = (m_q.size() > 0) ? 1'($urandom) : ($urandom_range(59) == 0);
      mem_rdata = $urandom;
      reset = ($urandom_range(299) != 0);
      tick();
      if (!reset) begin
        inst_pend = 1'b0; data_pend = 1'b0;
      end else begin
        if (m_inst_acc) inst_pend = 1'b0;
        if (m_data_acc) data_pend = 1'b0;
      end
    end
    reset = 1'b1;
    quiet();
    tick(); tick();

    if (resp_q.size() != 0) begin
      miscompares++;
      $display("FAIL resp_leftover got %0d pending want 0", resp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
